// File: rtl/wb_bus_matrix.sv
// Wishbone bus matrix: N_MASTERS round-robin arbitrated masters routed to N_SLAVES
// address-decoded slaves, one transaction in flight, with decode and timeout error termination.
module wb_bus_matrix #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 17,
  parameter int SEL_LSB   = 12,
  parameter int SEL_W     = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_MASTERS-1:0]      m_STB,
  input  logic [N_MASTERS-1:0]      m_WE,
  input  logic [32*N_MASTERS-1:0]   m_ADDR,
  input  logic [32*N_MASTERS-1:0]   m_DAT_I,
  output logic [32*N_MASTERS-1:0]   m_DAT_O,
  output logic [N_MASTERS-1:0]      m_ACK,
  output logic [N_MASTERS-1:0]      m_ERR,
  output logic [N_SLAVES-1:0]       s_STB,
  output logic                      s_WE,
  output logic [31:0]               s_ADDR,
  output logic [31:0]               s_DAT_O,
  input  logic [32*N_SLAVES-1:0]    s_DAT_I,
  input  logic [N_SLAVES-1:0]       s_ACK
);

  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t           r_state, w_next_state;
  logic [GW-1:0]    r_grant, r_last, w_pick;
  logic [SEL_W-1:0] r_sel, w_pick_sel;
  logic [9:0]       r_tcnt;
  logic             w_any_req, w_stb_g, w_we_g, w_dec_err, w_ack_sel, w_tmo;
  logic [31:0]      w_addr_g, w_wdat_g, w_rdat_sel;

  // Round-robin pick: smallest distance k from last+1 wins, so scan k downward and overwrite.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    w_any_req  = 1'b0;
    w_pick     = r_last;
    w_pick_sel = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (m_STB[i] && (((int'(r_last) + k) % N_MASTERS) == i)) begin
          w_any_req = 1'b1;
          w_pick    = GW'(i);
        end
      end
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_pick == GW'(i)) w_pick_sel = m_ADDR[32*i+SEL_LSB +: SEL_W];
    end
  end

  // Signals of the granted master and the selected slave.
  always_comb begin
    w_stb_g    = 1'b0;
    w_we_g     = 1'b0;
    w_addr_g   = '0;
    w_wdat_g   = '0;
    w_ack_sel  = 1'b0;
    w_rdat_sel = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_grant == GW'(i)) begin
        w_stb_g  = m_STB[i];
        w_we_g   = m_WE[i];
        w_addr_g = m_ADDR[32*i +: 32];
        w_wdat_g = m_DAT_I[32*i +: 32];
      end
    end
    for (int j = 0; j < N_SLAVES; j++) begin
      if (r_sel == SEL_W'(j)) begin
        w_ack_sel  = s_ACK[j];
        w_rdat_sel = s_DAT_I[32*j +: 32];
      end
    end
  end

  assign w_dec_err = (int'(r_sel) >= N_SLAVES);
  assign w_tmo     = (r_tcnt == 10'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears
  // control registers so every output falls to 0 the moment reset goes low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= GW'(N_MASTERS - 1);
      r_sel   <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_sel   <= w_pick_sel;
            r_tcnt  <= '0;
          end
        end
        BUSY: begin
          if (!w_dec_err && w_stb_g && !w_ack_sel && !w_tmo) r_tcnt <= r_tcnt + 10'd1;
        end
        default: ;
      endcase
    end
  end

  // Decode error beats abort, abort beats ACK, ACK beats timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = BUSY;
      BUSY: begin
        if (w_dec_err)      w_next_state = RELEASE;
        else if (!w_stb_g)  w_next_state = IDLE;
        else if (w_ack_sel) w_next_state = RELEASE;
        else if (w_tmo)     w_next_state = RELEASE;
      end
      RELEASE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    m_DAT_O = '0;
    m_ACK   = '0;
    m_ERR   = '0;
    s_STB   = '0;
    s_WE    = 1'b0;
    s_ADDR  = '0;
    s_DAT_O = '0;
    if (r_state == BUSY) begin
      s_WE    = w_we_g;
      s_ADDR  = w_addr_g;
      s_DAT_O = w_wdat_g;
      for (int j = 0; j < N_SLAVES; j++) begin
        if (!w_dec_err && (r_sel == SEL_W'(j))) s_STB[j] = w_stb_g;
      end
      for (int i = 0; i < N_MASTERS; i++) begin
        if (r_grant == GW'(i)) begin
          if (w_dec_err) begin
            m_ERR[i] = 1'b1;
          end else if (w_stb_g) begin
            if (w_ack_sel) begin
              m_ACK[i]          = 1'b1;
              m_DAT_O[32*i +: 32] = w_rdat_sel;
            end else if (w_tmo) begin
              m_ERR[i] = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_bus_matrix.sv
// Self-checking bench for wb_bus_matrix: slave model with per-slave wait states, and a
// scoreboard of expected master completions compared whenever a master sees ACK or ERR.
module tb_wb_bus_matrix;

  localparam int NM = 2;
  localparam int NS = 17;

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     m_STB, m_WE;
  logic [32*NM-1:0]  m_ADDR, m_DAT_I, m_DAT_O;
  logic [NM-1:0]     m_ACK, m_ERR;
  logic [NS-1:0]     s_STB;
  logic              s_WE;
  logic [31:0]       s_ADDR, s_DAT_O;
  logic [32*NS-1:0]  s_DAT_I;
  logic [NS-1:0]     s_ACK;

  wb_bus_matrix #(.N_MASTERS(NM), .N_SLAVES(NS), .SEL_LSB(12), .SEL_W(5), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .m_STB(m_STB), .m_WE(m_WE), .m_ADDR(m_ADDR), .m_DAT_I(m_DAT_I),
    .m_DAT_O(m_DAT_O), .m_ACK(m_ACK), .m_ERR(m_ERR),
    .s_STB(s_STB), .s_WE(s_WE), .s_ADDR(s_ADDR), .s_DAT_O(s_DAT_O),
    .s_DAT_I(s_DAT_I), .s_ACK(s_ACK)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model: slave j acks after wait_req[j] wait cycles of continuous strobe.
  int          wait_req [NS];
  bit          ack_en   [NS];
  logic [31:0] sdata    [NS];
  int          wcnt     [NS];

  always_comb begin
    s_ACK   = '0;
    s_DAT_I = '0;
    for (int j = 0; j < NS; j++) begin
      s_ACK[j]          = s_STB[j] && ack_en[j] && (wcnt[j] >= wait_req[j]);
      s_DAT_I[32*j +: 32] = sdata[j];
    end
  end

  always @(posedge clk) begin
    for (int j = 0; j < NS; j++) begin
      if (!s_STB[j] || s_ACK[j]) wcnt[j] <= 0;
      else                       wcnt[j] <= wcnt[j] + 1;
    end
  end

  typedef struct {
    int          m;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   done_cnt = 0;

  // Scoreboard monitor: each ACK/ERR pops the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NM; i++) begin
        if (m_ACK[i] || m_ERR[i]) begin
          done_cnt++;
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: master %0d ack=%b err=%b at cycle %0d, nothing expected",
                     i, m_ACK[i], m_ERR[i], cyc);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.m != i || m_ERR[i] !== mon_e.err || m_ACK[i] !== !mon_e.err ||
                (!mon_e.err && m_DAT_O[32*i +: 32] !== mon_e.data)) begin
              n_fail++;
              $display("FAIL completion: got master %0d ack=%b err=%b data=%h, expected master %0d err=%b data=%h",
                       i, m_ACK[i], m_ERR[i], m_DAT_O[32*i +: 32], mon_e.m, mon_e.err, mon_e.data);
            end
          end
          n_checks++;
          for (int o = 0; o < NM; o++) begin
            if (o != i && (m_ACK[o] || m_ERR[o] || m_DAT_O[32*o +: 32] != 32'h0)) begin
              n_fail++;
              $display("FAIL non_granted_quiet: master %0d ack=%b err=%b data=%h, expected all 0",
                       o, m_ACK[o], m_ERR[o], m_DAT_O[32*o +: 32]);
            end
          end
        end
      end
    end
  end

  task automatic req(input int m, input logic [31:0] addr, input logic we, input logic [31:0] wd);
    m_STB[m]            = 1'b1;
    m_WE[m]             = we;
    m_ADDR[32*m +: 32]  = addr;
    m_DAT_I[32*m +: 32] = wd;
  endtask

  task automatic drop(input int m);
    m_STB[m]            = 1'b0;
    m_WE[m]             = 1'b0;
    m_ADDR[32*m +: 32]  = '0;
    m_DAT_I[32*m +: 32] = '0;
  endtask

  task automatic apply_reset();
    reset   = 1'b0;
    m_STB   = '0;
    m_WE    = '0;
    m_ADDR  = '0;
    m_DAT_I = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_done(input int m, input int budget, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (m_ACK[m] || m_ERR[m]) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: master %0d got no ACK/ERR, expected one within %0d cycles", name, m, budget);
    end
    @(posedge clk); #1;
    drop(m);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req(0, 32'h0000_1004, 1'b1, 32'h1111_1111);
    req(1, 32'h0000_2008, 1'b0, 32'h2222_2222);
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({s_STB, s_WE, s_ADDR, s_DAT_O, m_ACK, m_ERR, m_DAT_O} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: s_STB=%h s_ADDR=%h m_ACK=%b m_ERR=%b, expected all 0",
                 s_STB, s_ADDR, m_ACK, m_ERR);
      end
    end
    drop(0);
    drop(1);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s_STB, s_WE, s_ADDR, s_DAT_O, m_ACK, m_ERR, m_DAT_O} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: s_STB=%h s_ADDR=%h m_ACK=%b, expected all 0", s_STB, s_ADDR, m_ACK);
    end
  endtask

  task automatic test_single_read();
    sdata[1] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req(0, 32'h0000_1004, 1'b0, 32'h0);
    sb.push_back('{0, 1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    n_checks++;
    if (s_STB !== '0) begin
      n_fail++;
      $display("FAIL single_cycle0: s_STB=%h, expected 0", s_STB);
    end
    @(negedge clk);
    n_checks++;
    if (s_STB !== 17'h2) begin
      n_fail++;
      $display("FAIL single_stb: s_STB=%h, expected 00002", s_STB);
    end
    n_checks++;
    if (m_ACK !== 2'b01 || m_DAT_O[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_ack: m_ACK=%b data=%h, expected 01 deadbeef", m_ACK, m_DAT_O[31:0]);
    end
    n_checks++;
    if (s_ADDR !== 32'h0000_1004 || s_WE !== 1'b0) begin
      n_fail++;
      $display("FAIL single_addr: s_ADDR=%h s_WE=%b, expected 00001004 0", s_ADDR, s_WE);
    end
    @(posedge clk); #1;
    drop(0);
    @(negedge clk);
    n_checks++;
    if (s_STB !== '0 || m_ACK !== '0 || m_ERR !== '0) begin
      n_fail++;
      $display("FAIL single_release: s_STB=%h m_ACK=%b m_ERR=%b, expected 0", s_STB, m_ACK, m_ERR);
    end
    // A request presented in cycle 3 is sampled there, proving the matrix is back in IDLE.
    @(posedge clk); #1;
    req(0, 32'h0000_1008, 1'b0, 32'h0);
    sb.push_back('{0, 1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (s_STB !== 17'h2) begin
      n_fail++;
      $display("FAIL single_idle_cycle3: s_STB=%h in cycle 4, expected 00002", s_STB);
    end
    @(posedge clk); #1;
    drop(0);
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int t[4];
    int n = 0;
    apply_reset();
    sdata[2] = 32'hA000_0002;
    sdata[3] = 32'hA000_0003;
    @(posedge clk); #1;
    req(0, 32'h0000_2000, 1'b0, 32'h0);
    req(1, 32'h0000_3000, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{0, 1'b0, 32'hA000_0002});
      sb.push_back('{1, 1'b0, 32'hA000_0003});
    end
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      if (m_ACK != '0) begin
        t[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    drop(0);
    drop(1);
    n_checks++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL rr_count: %0d ACKs seen, expected 4", n);
    end else begin
      for (int k = 1; k < 4; k++) begin
        n_checks++;
        if (t[k] - t[k-1] != 3) begin
          n_fail++;
          $display("FAIL rr_spacing: ACK %0d came %0d cycles after previous, expected 3", k, t[k] - t[k-1]);
        end
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rr_drain: %0d expected completions left, expected 0", sb.size());
    end
  endtask

  task automatic test_timeout();
    int  busy    = 0;
    bit  got_err = 1'b0;
    bit  saw_ack = 1'b0;
    bit  bus_ok  = 1'b1;
    ack_en[4] = 1'b0;
    @(posedge clk); #1;
    req(0, 32'h0000_4000, 1'b1, 32'h1234_5678);
    sb.push_back('{0, 1'b1, 32'h0});
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (s_STB[4]) begin
        busy++;
        if (s_WE !== 1'b1 || s_DAT_O !== 32'h1234_5678 || s_ADDR !== 32'h0000_4000) bus_ok = 1'b0;
      end
      if (m_ACK != '0) saw_ack = 1'b1;
      if (m_ERR[0]) begin
        got_err = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    drop(0);
    @(negedge clk);
    n_checks++;
    if (!got_err || busy != 255) begin
      n_fail++;
      $display("FAIL timeout_cycle: err=%b in BUSY cycle %0d, expected 1 in cycle 255", got_err, busy);
    end
    n_checks++;
    if (s_STB[4] !== 1'b0 || m_ERR !== '0) begin
      n_fail++;
      $display("FAIL timeout_release: s_STB[4]=%b m_ERR=%b, expected 0 00", s_STB[4], m_ERR);
    end
    n_checks++;
    if (saw_ack || !bus_ok) begin
      n_fail++;
      $display("FAIL timeout_bus: ack_seen=%b bus_ok=%b, expected 0 1", saw_ack, bus_ok);
    end
    ack_en[4] = 1'b1;
  endtask

  task automatic test_decode_err();
    bit any_stb = 1'b0;
    int errc    = -1;
    @(posedge clk); #1;
    req(0, 32'h0001_4000, 1'b0, 32'h0);
    sb.push_back('{0, 1'b1, 32'h0});
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (s_STB != '0) any_stb = 1'b1;
      if (m_ERR[0]) begin
        errc = n;
        break;
      end
    end
    @(posedge clk); #1;
    drop(0);
    repeat (2) begin
      @(negedge clk);
      if (s_STB != '0) any_stb = 1'b1;
    end
    n_checks++;
    if (errc != 1) begin
      n_fail++;
      $display("FAIL decode_err_cycle: ERR at cycle %0d after request, expected 1", errc);
    end
    n_checks++;
    if (any_stb) begin
      n_fail++;
      $display("FAIL decode_no_stb: s_STB was set, expected never");
    end
  endtask

  task automatic test_abort();
    wait_req[5] = 10;
    sdata[6]    = 32'hA000_0006;
    @(posedge clk); #1;
    req(1, 32'h0000_5000, 1'b0, 32'h0);
    sb.push_back('{0, 1'b0, 32'hA000_0006});
    @(negedge clk);
    @(posedge clk); #1;
    req(0, 32'h0000_6000, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (s_STB !== 17'h20) begin
      n_fail++;
      $display("FAIL abort_busy: s_STB=%h, expected 00020", s_STB);
    end
    @(posedge clk); #1;
    drop(1);
    @(negedge clk);
    n_checks++;
    if (s_STB !== '0 || m_ACK !== '0 || m_ERR !== '0) begin
      n_fail++;
      $display("FAIL abort_drop: s_STB=%h m_ACK=%b m_ERR=%b, expected 0", s_STB, m_ACK, m_ERR);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (s_STB !== 17'h40 || m_ACK !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_next_grant: s_STB=%h m_ACK=%b, expected 00040 01", s_STB, m_ACK);
    end
    @(posedge clk); #1;
    drop(0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    wait_req[7] = 20;
    sdata[7]    = 32'hA000_0007;
    sdata[8]    = 32'hA000_0008;
    @(posedge clk); #1;
    req(1, 32'h0000_7000, 1'b1, 32'hCAFE_0007);
    @(negedge clk);
    @(posedge clk); #1;
    req(0, 32'h0000_8000, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (s_STB !== 17'h80) begin
      n_fail++;
      $display("FAIL resetmid_busy: s_STB=%h, expected 00080", s_STB);
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (s_STB !== '0 || m_ACK !== '0 || m_ERR !== '0 || s_ADDR !== '0) begin
      n_fail++;
      $display("FAIL resetmid_async: s_STB=%h m_ACK=%b m_ERR=%b s_ADDR=%h, expected 0",
               s_STB, m_ACK, m_ERR, s_ADDR);
    end
    @(negedge clk);
    sb.push_back('{0, 1'b0, 32'hA000_0008});
    sb.push_back('{1, 1'b0, 32'hA000_0007});
    reset = 1'b1;
    wait_done(0, 10, "resetmid_m0_first");
    wait_done(1, 40, "resetmid_m1_second");
    @(negedge clk);
  endtask

  initial begin
    for (int j = 0; j < NS; j++) begin
      wait_req[j] = 0;
      ack_en[j]   = 1'b1;
      sdata[j]    = 32'hB000_0000 | 32'(j);
    end
    m_STB   = '0;
    m_WE    = '0;
    m_ADDR  = '0;
    m_DAT_I = '0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout();
    test_decode_err();
    test_abort();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: %0d expected completions never arrived, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bus_matrix.md
# wb_bus_matrix

Parametrised Wishbone bus matrix that replaces the single-master interconnect between bus masters (CPU, future DMA/video fetch) and the memory-mapped slaves (RAM, seven-seg, VGA, keyboard, counter). It accepts `N_MASTERS` masters and routes them to `N_SLAVES` slaves. Masters are arbitrated round-robin. The matrix decodes the slave from an address field and terminates a hung or unmapped access with an error strobe. Exactly one transaction is in flight at a time.

## Interface
Parameters:
- `N_MASTERS`, 2: number of masters (1..8).
- `N_SLAVES`, 17: number of slaves (1..32).
- `SEL_LSB`, 12: lowest address bit of the slave-select field.
- `SEL_W`, 5: width of the slave-select field.
- `TIMEOUT`, 255: BUSY cycles allowed without slave ACK before ERR (1..1023).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `m_STB` in N_MASTERS: per-master request, held until ACK/ERR.
- `m_WE` in N_MASTERS: per-master write enable.
- `m_ADDR` in 32*N_MASTERS: master i at bits [32i+31:32i].
- `m_DAT_I` in 32*N_MASTERS: master write data.
- `m_DAT_O` out 32*N_MASTERS: read data to masters.
- `m_ACK` out N_MASTERS: transfer-complete strobe.
- `m_ERR` out N_MASTERS: error-termination strobe.
- `s_STB` out N_SLAVES: one-hot slave strobe.
- `s_WE` out 1: write enable of the granted master.
- `s_ADDR` out 32: address of the granted master.
- `s_DAT_O` out 32: write data of the granted master.
- `s_DAT_I` in 32*N_SLAVES: slave j read data at bits [32j+31:32j].
- `s_ACK` in N_SLAVES: per-slave acknowledge.

## Operation
- State machine with states IDLE, BUSY and RELEASE.
  - Registers: `grant` (log2 N_MASTERS bits), `last` (previous grant), `sel` (SEL_W bits), `tcnt` (10 bits).
- IDLE:
  - If any `m_STB` is high, pick the first requesting master scanning from `last+1` upward, wrapping modulo N_MASTERS.
  - Register it in `grant` and `last`.
  - Register `sel = m_ADDR[grant][SEL_LSB+SEL_W-1:SEL_LSB]`.
  - Clear `tcnt` and go to BUSY.
  - If no `m_STB` is high, stay in IDLE.
- BUSY, with `g = grant`:
  - `s_WE`, `s_ADDR` and `s_DAT_O` mirror master g.
  - If `sel >= N_SLAVES`: drive no `s_STB`, assert `m_ERR[g]` this cycle, go to RELEASE.
  - Else: `s_STB[sel] = m_STB[g]`.
    - If `s_ACK[sel]`: `m_ACK[g] = 1` and `m_DAT_O[g] = s_DAT_I[sel]` combinationally in the same cycle, go to RELEASE.
    - Else if `tcnt == TIMEOUT-1`: `m_ERR[g] = 1`, go to RELEASE.
    - Else `tcnt++`.
  - If `m_STB[g]` drops before ACK/ERR (abort): go to IDLE with no ACK/ERR. `s_STB` falls in the same cycle.
- RELEASE: all strobes low for one cycle, then IDLE. This gives the master one cycle to drop or re-present STB.
- ACK/ERR precedence: `s_ACK` wins over timeout in the same cycle. The decode error wins over everything.
- Outputs to non-granted masters are always 0: `m_DAT_O`, `m_ACK`, `m_ERR`.
- `s_ADDR`, `s_WE` and `s_DAT_O` are 0 outside BUSY.
- Slave `s_ACK` outside BUSY, or from a non-selected slave, is ignored.
- `m_ADDR` and `m_DAT_I` must be stable while STB is held; the matrix does not re-decode mid-transaction.

## Timing
- `reset` low forces asynchronously:
  - state = IDLE, `grant` = 0, `last` = N_MASTERS-1 (master 0 wins first), `sel` = 0, `tcnt` = 0.
  - All outputs to 0.
- Reset mid-transaction drops `s_STB` immediately; the transaction is lost and no ACK/ERR is given.
- Latency:
  - STB sampled in IDLE at edge 0 gives `s_STB` high in cycle 1.
  - A slave ACK in cycle k gives `m_ACK` in cycle k.
  - Minimum occupancy is 3 cycles (IDLE, BUSY, RELEASE), so a zero-wait slave yields one transfer per 3 cycles.
- Timeout: ERR is asserted in BUSY cycle number TIMEOUT, counting the first BUSY cycle as 1.
- Starvation bound: a waiting master is granted within N_MASTERS-1 other transactions.

## Test plan
- Single master 0: read of addr 0x0000_1004 (sel 1), slave 1 ACKs in its 1st STB cycle with 0xDEAD_BEEF.
  - Required: `m_ACK[0]` and `m_DAT_O[0]` = 0xDEAD_BEEF in cycle 1, `s_STB` = 17'h2, IDLE at cycle 3.
- Masters 0 and 1 both hold STB continuously, zero-wait slave.
  - Required: grants alternate 0,1,0,1. Each ACK is spaced 3 cycles apart. Non-granted `m_ACK`/`m_DAT_O` stay 0.
- Master 0 write to sel 4, slave never ACKs, TIMEOUT=255.
  - Required: `m_ERR[0]` pulses in BUSY cycle 255, `s_STB[4]` is low the next cycle, no `m_ACK`.
- Address with sel = 20 (≥17).
  - Required: no `s_STB` bit ever set, `m_ERR` in the first BUSY cycle.
- Master 1 drops STB in BUSY cycle 3 before ACK.
  - Required: back to IDLE next edge, no ACK/ERR. A pending master 0 is granted next.
- Assert `reset` low mid-BUSY with a wait-stated slave.
  - Required: `s_STB` = 0 asynchronously.
  - After release, master 0 is granted first even if master 1 also requests.
